// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, default round
// configuration, FSM state encoding and 28-bit rotate helpers.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    // Bit i set: round i+1 rotates by one place, otherwise by two.
    localparam logic [15:0] DES_SHIFT_MASK = 16'h8103;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Permuted choice 1: 1-based source bit (1 = key MSB) for each output bit, MSB first.
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: 1-based source bit of the 56-bit C/D word, MSB first.
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
        logic [55:0] t;
        t = {x, x} << amt;
        return t[55:28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        logic [55:0] t;
        t = {x, x} >> amt;
        return t[27:0];
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-schedule bus between the key requester/round datapath and the schedule.
//
// Handshake: subkey is transferred on a rising edge where subkey_valid and
// subkey_ready are both 1. Once subkey_valid rises, it stays high and subkey /
// round_idx stay stable until that transfer happens; ready may toggle freely
// and never combinationally depends on valid.
interface des_key_schedule_if #(
    parameter int RW = 4
);
    import des_pkg::*;

    logic          start;
    logic          decrypt;
    logic [63:0]   key_in;
    logic [47:0]   subkey;
    logic          subkey_valid;
    logic          subkey_ready;
    logic [RW-1:0] round_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );

endinterface

// File: rtl/des_key_perm.sv
// Purely combinational DES key permutations: PC-1 (64 -> 56, parity bits
// dropped) and PC-2 (56 -> 48). Shared with the round datapath.
module des_key_perm
    import des_pkg::*;
(
    input  logic [63:0] key_i,
    input  logic [55:0] cd_i,
    output logic [55:0] pc1_o,
    output logic [47:0] subkey_o
);

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_o[55-i] = key_i[64-PC1[i]];
    end

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey_o[47-i] = cd_i[56-PC2[i]];
    end

    // Parity bits (every eighth key bit) take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key-schedule generator: loads PC-1 of the key into C/D, then streams one
// PC-2 subkey per accepted handshake in encrypt (K1..Kn) or decrypt (Kn..K1)
// order, rotating C/D left or right between rounds.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int                ROUNDS     = DES_ROUNDS,
    parameter logic [ROUNDS-1:0] SHIFT_MASK = DES_SHIFT_MASK,
    parameter int                RW         = $clog2(ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    des_key_schedule_if.slave   bus,
    output logic [1:0]          state_o
);

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    function automatic int rot_total(input logic [ROUNDS-1:0] m);
        int t = 0;
        for (int i = 0; i < ROUNDS; i++) t += m[i] ? 1 : 2;
        return t;
    endfunction

    // Decrypt starts from unrotated C0D0, which only equals C16D16 when the
    // rotations wrap the 28-bit halves exactly once.
    if (rot_total(SHIFT_MASK) != 28) begin : g_bad_shift_mask
        $error("des_key_schedule: SHIFT_MASK rotations do not sum to 28");
    end

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [27:0]   c_q, c_d;
    logic [27:0]   d_q, d_d;
    logic          mode_q, mode_d;

    logic [55:0]   pc1_key;
    logic [47:0]   subkey;
    logic [RW-1:0] enc_idx;
    logic [RW-1:0] dec_idx;
    logic [1:0]    first_amt;
    logic [1:0]    enc_amt;
    logic [1:0]    dec_amt;

    des_key_perm u_perm (
        .key_i    (bus.key_in),
        .cd_i     ({c_q, d_q}),
        .pc1_o    (pc1_key),
        .subkey_o (subkey)
    );

    // Encrypt step after round cnt+1 uses s(cnt+2); decrypt uses s(ROUNDS-cnt),
    // whose mask bit is also the decrypt round index.
    assign enc_idx   = cnt_q + 1'b1;
    assign dec_idx   = LAST - cnt_q;
    assign first_amt = SHIFT_MASK[0]       ? 2'd1 : 2'd2;
    assign enc_amt   = SHIFT_MASK[enc_idx] ? 2'd1 : 2'd2;
    assign dec_amt   = SHIFT_MASK[dec_idx] ? 2'd1 : 2'd2;

    // Next-state logic for the FSM, round counter and C/D halves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        d_d     = d_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.decrypt;
                    cnt_d   = '0;
                    state_d = ROUND;
                    if (bus.decrypt) begin
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rotl28(pc1_key[55:28], first_amt);
                        d_d = rotl28(pc1_key[27:0], first_amt);
                    end
                end
            end
            ROUND: begin
                if (bus.subkey_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (mode_q) begin
                            c_d = rotr28(c_q, dec_amt);
                            d_d = rotr28(d_q, dec_amt);
                        end else begin
                            c_d = rotl28(c_q, enc_amt);
                            d_d = rotl28(d_q, enc_amt);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.subkey       = subkey;
    assign bus.subkey_valid = (state_q == ROUND);
    assign bus.round_idx    = mode_q ? dec_idx : cnt_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign state_o          = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known-answer runs, random keys,
// random stalls, ignored starts and mid-schedule reset against a bit-level
// reference of the DES key schedule.
module tb_des_key_schedule;

    logic       clk;
    logic       rst;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    des_key_schedule_if #(.RW(4)) bus ();

    des_key_schedule dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

    int TB_SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int TB_PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    int TB_PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Reference: subkey K(round), round in 1..16, from the cumulative rotation
    // of the PC-1 halves, using 1-based MSB-first bit numbering.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int round);
        bit          kb [1:64];
        bit          c0 [1:28];
        bit          d0 [1:28];
        bit          cd [1:56];
        int          tot;
        logic [47:0] k;
        for (int j = 1; j <= 64; j++) kb[j] = key[64-j];
        for (int j = 1; j <= 28; j++) begin
            c0[j] = kb[TB_PC1[j-1]];
            d0[j] = kb[TB_PC1[j+27]];
        end
        tot = 0;
        for (int r = 1; r <= round; r++) tot += TB_SHIFTS[r-1];
        for (int j = 1; j <= 28; j++) begin
            cd[j]    = c0[((j - 1 + tot) % 28) + 1];
            cd[j+28] = d0[((j - 1 + tot) % 28) + 1];
        end
        k = '0;
        for (int j = 1; j <= 48; j++) k = {k[46:0], cd[TB_PC2[j-1]]};
        return k;
    endfunction

    // Starts one schedule from an IDLE negedge and checks every presented
    // subkey, the done pulse timing and the return to IDLE. Leaves the bench
    // at a negedge in IDLE so the next schedule can start immediately.
    task automatic run_schedule(input logic [63:0] key, input bit dec, input int stall_pct,
                                input bit poke, input string tag,
                                output logic [47:0] first_o, output logic [47:0] last_o);
        logic [47:0] exp_k [$];
        logic [3:0]  exp_i [$];
        int          cyc;
        int          stalls;
        int          hs;
        for (int n = 0; n < 16; n++) begin
            int r;
            r = dec ? 16 - n : n + 1;
            exp_k.push_back(ref_subkey(key, r));
            exp_i.push_back(4'(r - 1));
        end
        first_o = 'x;
        last_o  = 'x;
        bus.start        = 1'b1;
        bus.key_in       = key;
        bus.decrypt      = dec;
        bus.subkey_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc    = 1;
        stalls = 0;
        hs     = 0;
        while (exp_k.size() != 0 && cyc < 200) begin
            bus.subkey_ready = ($urandom_range(0, 99) >= stall_pct);
            bus.start        = 1'b0;
            if (poke && (cyc == 4 || exp_k.size() == 1)) begin
                bus.start   = 1'b1;
                bus.key_in  = ~key;
                bus.decrypt = ~dec;
                if (exp_k.size() == 1) bus.subkey_ready = 1'b1;
            end
            vectors++;
            if (bus.subkey_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.subkey !== exp_k[0] || bus.round_idx !== exp_i[0]) begin
                miscompares++;
                $display("FAIL %s round cyc=%0d: got valid=%b busy=%b done=%b subkey=%h idx=%0d, expected valid=1 busy=1 done=0 subkey=%h idx=%0d",
                         tag, cyc, bus.subkey_valid, bus.busy, bus.done, bus.subkey,
                         bus.round_idx, exp_k[0], exp_i[0]);
            end
            if (bus.subkey_ready) begin
                if (hs == 0) first_o = bus.subkey;
                last_o = bus.subkey;
                hs++;
                void'(exp_k.pop_front());
                void'(exp_i.pop_front());
            end else begin
                stalls++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b0;
        if (exp_k.size() != 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d subkeys outstanding, expected 0", tag, exp_k.size());
        end
        // DONE cycle: one-cycle pulse, exactly ROUNDS+1+stalls cycles after start.
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.subkey_valid !== 1'b0 ||
            cyc != 17 + stalls) begin
            miscompares++;
            $display("FAIL %s done: got done=%b busy=%b valid=%b at cycle %0d, expected done=1 busy=1 valid=0 at cycle %0d",
                     tag, bus.done, bus.busy, bus.subkey_valid, cyc, 17 + stalls);
        end
        // A start during DONE must be ignored.
        bus.start   = 1'b1;
        bus.key_in  = ~key;
        bus.decrypt = ~dec;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.subkey_valid !== 1'b0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL %s idle_after_done: got done=%b busy=%b valid=%b state=%0d, expected 0 0 0 0",
                     tag, bus.done, bus.busy, bus.subkey_valid, state);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.decrypt      = 1'b1;
        bus.key_in       = KAT_KEY;
        bus.subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (state !== 2'd0 || bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.round_idx !== 4'd0 || bus.subkey !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_values: got state=%0d valid=%b busy=%b done=%b idx=%0d subkey=%h, expected all zero",
                     state, bus.subkey_valid, bus.busy, bus.done, bus.round_idx, bus.subkey);
        end
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        rst         = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (state !== 2'd0 || bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got state=%0d valid=%b busy=%b done=%b, expected 0 0 0 0",
                     state, bus.subkey_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_encrypt();
        logic [47:0] f, l;
        run_schedule(KAT_KEY, 1'b0, 0, 1'b0, "encrypt_kat", f, l);
        vectors++;
        if (f !== KAT_K1 || l !== KAT_K16) begin
            miscompares++;
            $display("FAIL encrypt_kat_ends: got first=%h last=%h, expected first=%h last=%h", f, l, KAT_K1, KAT_K16);
        end
    endtask

    task automatic test_decrypt();
        logic [47:0] f, l;
        run_schedule(KAT_KEY, 1'b1, 0, 1'b0, "decrypt_kat", f, l);
        vectors++;
        if (f !== KAT_K16 || l !== KAT_K1) begin
            miscompares++;
            $display("FAIL decrypt_kat_ends: got first=%h last=%h, expected first=%h last=%h", f, l, KAT_K16, KAT_K1);
        end
    endtask

    task automatic test_stall();
        logic [47:0] f, l;
        run_schedule(KAT_KEY, 1'b0, 30, 1'b0, "stall_enc", f, l);
        run_schedule(KAT_KEY, 1'b1, 30, 1'b0, "stall_dec", f, l);
        run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 30, 1'b0, "stall_rand", f, l);
    endtask

    task automatic test_start_ignored();
        logic [47:0] f, l;
        run_schedule(KAT_KEY, 1'b0, 0, 1'b1, "start_ignored_enc", f, l);
        run_schedule({$urandom, $urandom}, 1'b1, 30, 1'b1, "start_ignored_dec", f, l);
    endtask

    task automatic test_reset_mid();
        logic [47:0] f, l;
        int          wait_cyc;
        bus.start        = 1'b1;
        bus.key_in       = KAT_KEY;
        bus.decrypt      = 1'b0;
        bus.subkey_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc  = 0;
        while (!(bus.subkey_valid === 1'b1 && bus.round_idx === 4'd7) && wait_cyc < 30) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (wait_cyc >= 30) begin
            vectors++;
            miscompares++;
            $display("FAIL reset_mid_wait: round 7 never presented within %0d cycles", wait_cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.subkey_ready = 1'b0;
        vectors++;
        if (state !== 2'd0 || bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.subkey !== 48'h0 || bus.round_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got state=%0d valid=%b busy=%b done=%b subkey=%h idx=%0d, expected all zero",
                     state, bus.subkey_valid, bus.busy, bus.done, bus.subkey, bus.round_idx);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
        end
        run_schedule(KAT_KEY, 1'b0, 0, 1'b0, "after_reset", f, l);
        vectors++;
        if (f !== KAT_K1 || l !== KAT_K16) begin
            miscompares++;
            $display("FAIL after_reset_ends: got first=%h last=%h, expected first=%h last=%h", f, l, KAT_K1, KAT_K16);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] f, l;
        for (int n = 0; n < 6; n++) begin
            run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), (n % 2) * 30, 1'b0,
                         "back_to_back", f, l);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.decrypt      = 1'b0;
        bus.key_in       = '0;
        bus.subkey_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Parametrised DES key-schedule generator that replaces the fixed 16-round key-control FSM. It holds the C/D key halves and applies PC-1, the per-round rotations and PC-2 itself. It streams one 48-bit subkey per round to the round datapath over a valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits between the key input register and the Feistel round unit.

## Interface
Parameters:
- ROUNDS, 16, number of subkeys generated per key.
- SHIFT_MASK, 16'h8103, bit i set means round i+1 rotates by 1; clear means it rotates by 2. Width is ROUNDS. The sum of rotations must equal 28; this is checked at elaboration.
- RW, $clog2(ROUNDS), width of round_idx.

Ports:
- clk, in, 1, clock. All state changes on the rising edge.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, request a new schedule. Accepted only in IDLE.
- decrypt, in, 1, sampled with start. 0 gives K1..K16; 1 gives K16..K1.
- key_in, in, 64, DES key with parity bits. Sampled with start; parity bits are ignored.
- subkey, out, 48, current subkey, PC-2 of the C/D registers.
- subkey_valid, out, 1, subkey and round_idx are valid.
- subkey_ready, in, 1, consumer accepts the subkey when subkey_valid=1 and subkey_ready=1.
- round_idx, out, RW, zero-based index of the presented subkey. Value k means K(k+1).
- busy, out, 1, high in ROUND and DONE.
- done, out, 1, one-cycle pulse after the last subkey is accepted.

## Operation
- States: IDLE, ROUND, DONE.
- Rotation amount s(i) for round i in 1..ROUNDS: s(i) = 1 if SHIFT_MASK[i-1] is set, else 2.
- IDLE with start=1:
  - C,D <= PC1(key_in).
  - Encrypt: rotated left by s(1).
  - Decrypt: not rotated, since the total rotation of 28 makes C16D16 = C0D0.
  - mode <= decrypt; cnt <= 0; go to ROUND.
- ROUND:
  - subkey_valid=1; subkey = PC2(C,D), combinational from the registers.
  - round_idx = cnt for encrypt, ROUNDS-1-cnt for decrypt.
- Handshake in ROUND with cnt < ROUNDS-1:
  - cnt++.
  - Encrypt: C,D rotate left by s(cnt+2).
  - Decrypt: C,D rotate right by s(ROUNDS-cnt).
  - C and D rotate independently, each 28 bits.
- Handshake in ROUND with cnt = ROUNDS-1: go to DONE.
- No handshake (subkey_ready=0): C, D, cnt and subkey are held stable. The valid/ready rule applies: subkey_valid never drops without a handshake.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- start while busy is ignored; key_in and decrypt are not sampled.
- Intermediate C/D values are not cleared after DONE. subkey is don't-care whenever subkey_valid=0.

## Timing
- Reset values: state=IDLE, cnt=0, C=D=0, mode=0, subkey_valid=0, busy=0, done=0, round_idx=0, subkey=PC2(0)=0.
- Reset mid-schedule returns to IDLE on the next edge with no done pulse.
- Start latency: start is accepted on edge T; subkey_valid=1 with the first subkey from cycle T+1.
- Throughput: one subkey per cycle while subkey_ready=1. ROUNDS subkeys occupy cycles T+1..T+ROUNDS.
- With no stalls, done is high in cycle T+ROUNDS+1. A new start is accepted at T+ROUNDS+2 at the earliest.
- Each stall cycle delays all later events by one cycle.
- Last-round handshake and start in the same cycle: start is ignored, because the state is still ROUND.

## Structure
- Package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries) as localparam arrays.
  - Default ROUNDS and SHIFT_MASK.
  - State enum {IDLE, ROUND, DONE}.
  - Functions rotl28 and rotr28 taking a rotation amount.
- One sub-module, des_key_perm: purely combinational PC-1 (64→56) and PC-2 (56→48) permutations, reused by the round datapath team.
- The FSM, counter and C/D registers live in des_key_schedule.

## Test plan
- Reset, then idle: all outputs at their reset values. start while rst=1 → no transition.
- key_in=64'h133457799BBCDFF1, decrypt=0, ready held 1 → 16 subkeys on consecutive cycles. First is 48'h1B02EFFC7072 with round_idx=0; last is 48'hCB3D8B0E17F5 with round_idx=15. done in cycle T+17.
- Same key with decrypt=1 → first subkey 48'hCB3D8B0E17F5 with round_idx=15; last 48'h1B02EFFC7072 with round_idx=0. The full sequence is the exact reverse of the encrypt run.
- Random subkey_ready stalls (30% low) → subkey and round_idx stable while stalled. Same 16 values as the unstalled run, and exactly 16 handshakes.
- start pulsed during ROUND with a different key → ignored; sequence unchanged.
- rst asserted at round 7 → IDLE next cycle with no done pulse. A new start then gives a correct full sequence.
